// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, reset
// polarity, stall-vector bit positions and the fetch FSM state encoding.
package if_fetch_unit_pkg;

    localparam int INST_BUS_LENGTH  = 16;
    localparam int INST_ADDR_LENGTH = 16;
    localparam logic RST_ENABLE     = 1'b1;
    localparam logic [15:0] ZERO16  = 16'h0000;

    localparam int STALL_W     = 6;
    // stall_i[STALL_FETCH] blocks launching a new fetch
    localparam int STALL_FETCH = 5;
    // stall_i[STALL_IFID] means IF/ID does not capture this cycle
    localparam int STALL_IFID  = 4;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_FETCH = 2'd1,
        IF_HOLD  = 2'd2,
        IF_DRAIN = 2'd3
    } if_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory bus between the fetch stage (master) and memory (slave).
//
// Handshake: the master raises inst_req_o with inst_addr_o and keeps both
// constant until it samples inst_ack_i=1 on a rising clk edge; that cycle
// completes the transfer and inst_rdata_i is valid only while inst_ack_i=1.
// The ack may arrive in the same cycle the request first appears. At most one
// request is outstanding.
interface if_fetch_unit_if
    import if_fetch_unit_pkg::*;
#(
    parameter int INST_W = INST_BUS_LENGTH,
    parameter int ADDR_W = INST_ADDR_LENGTH
);
    logic              inst_req_o;
    logic [ADDR_W-1:0] inst_addr_o;
    logic              inst_ack_i;
    logic [INST_W-1:0] inst_rdata_i;

    modport master (
        output inst_req_o,
        output inst_addr_o,
        input  inst_ack_i,
        input  inst_rdata_i
    );

    modport slave (
        input  inst_req_o,
        input  inst_addr_o,
        output inst_ack_i,
        output inst_rdata_i
    );
endinterface

// File: rtl/if_fetch_unit_hold_buf.sv
// One-entry {instruction, PC} holding register. Keeps a returned instruction
// alive while IF/ID is stalled. Clear wins over load.
module if_hold_buf
    import if_fetch_unit_pkg::*;
#(
    parameter int INST_W = INST_BUS_LENGTH,
    parameter int ADDR_W = INST_ADDR_LENGTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load,
    input  logic              clear,
    input  logic [INST_W-1:0] load_inst,
    input  logic [ADDR_W-1:0] load_pc,
    output logic              valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] pc
);

    // Capture or drop the single buffered entry.
    always_ff @(posedge clk_i) begin
        if (rst_i == RST_ENABLE) begin
            valid <= 1'b0;
            inst  <= '0;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            inst  <= '0;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= load_inst;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage. Owns the PC, drives the instruction-memory
// handshake and presents one {instruction, PC} per cycle to IF/ID. Redirects
// (flush over branch) retarget the PC; a request already on the bus is
// drained and its data thrown away.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                INST_W   = INST_BUS_LENGTH,
    parameter int                ADDR_W   = INST_ADDR_LENGTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  flush_pc_i,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    if_fetch_unit_if.master    mem,
    output logic [INST_W-1:0]  if_inst_o,
    output logic [ADDR_W-1:0]  if_PC_o,
    output logic               stallreq_o,
    output if_state_e          dbg_state_o
);

    if_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_inc;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;

    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              ack;

    logic              hold_load, hold_clear, hold_valid;
    logic [INST_W-1:0] hold_inst;
    logic [ADDR_W-1:0] hold_pc;

    // Low stall bits belong to later pipeline stages.
    logic unused_stall;
    assign unused_stall = ^stall_i[STALL_IFID-1:0];

    assign ack         = mem.inst_ack_i;
    assign redirect    = flush_i | branch_flag_i;
    assign redirect_pc = flush_i ? flush_pc_i : branch_target_i;
    assign pc_inc      = pc_q + PC_STEP;

    assign mem.inst_req_o  = req_q;
    assign mem.inst_addr_o = addr_q;
    assign dbg_state_o     = state_q;

    if_hold_buf #(
        .INST_W (INST_W),
        .ADDR_W (ADDR_W)
    ) u_hold_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load      (hold_load),
        .clear     (hold_clear),
        .load_inst (mem.inst_rdata_i),
        .load_pc   (pc_q),
        .valid     (hold_valid),
        .inst      (hold_inst),
        .pc        (hold_pc)
    );

    // Next state, next PC, hold-buffer control and the IF/ID-facing outputs.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_load  = 1'b0;
        hold_clear = 1'b0;
        if_inst_o  = '0;
        if_PC_o    = '0;
        stallreq_o = 1'b1;

        case (state_q)
            IF_IDLE: begin
                if (!stall_i[STALL_FETCH]) state_d = IF_FETCH;
            end
            IF_FETCH: begin
                if (ack) begin
                    if_inst_o  = mem.inst_rdata_i;
                    if_PC_o    = pc_q;
                    stallreq_o = 1'b0;
                    pc_d       = pc_inc;
                    if (stall_i[STALL_IFID]) begin
                        hold_load = 1'b1;
                        state_d   = IF_HOLD;
                    end else if (stall_i[STALL_FETCH]) begin
                        state_d = IF_IDLE;
                    end
                end
            end
            IF_HOLD: begin
                if (hold_valid) begin
                    if_inst_o  = hold_inst;
                    if_PC_o    = hold_pc;
                    stallreq_o = 1'b0;
                end
                if (!stall_i[STALL_IFID]) begin
                    hold_clear = 1'b1;
                    state_d    = stall_i[STALL_FETCH] ? IF_IDLE : IF_FETCH;
                end
            end
            IF_DRAIN: begin
                // Stale data from the pre-redirect address is dropped.
                if (ack) state_d = IF_FETCH;
            end
            default: state_d = IF_IDLE;
        endcase

        // A redirect kills whatever this cycle would have delivered.
        if (redirect) begin
            pc_d       = redirect_pc;
            hold_load  = 1'b0;
            hold_clear = 1'b1;
            if_inst_o  = '0;
            if_PC_o    = '0;
            stallreq_o = 1'b0;
            if ((state_q == IF_FETCH || state_q == IF_DRAIN) && !ack)
                state_d = IF_DRAIN;
            else
                state_d = IF_FETCH;
        end

        if (rst_i == RST_ENABLE) begin
            if_inst_o  = '0;
            if_PC_o    = '0;
            stallreq_o = 1'b0;
        end
    end

    // State, PC and the registered request/address driven onto the bus.
    always_ff @(posedge clk_i) begin
        if (rst_i == RST_ENABLE) begin
            state_q <= IF_IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= (state_d == IF_FETCH) || (state_d == IF_DRAIN);
            // DRAIN keeps the old address on the bus until its ack.
            if (state_d == IF_FETCH) addr_q <= pc_d;
        end
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage driving the IF side of the IF/ID pipeline register. Owns the PC, runs a request/acknowledge handshake with instruction memory, and presents one instruction plus its PC per cycle. A one-entry hold buffer prevents losing a returned instruction while the pipeline is stalled. Branch and flush redirects kill in-flight fetches cleanly.

## Interface
- `INST_W`, 16, instruction width (`INST_BUS_LENGTH`)
- `ADDR_W`, 16, address width (`INST_ADDR_LENGTH`)
- `RESET_PC`, 16'h0000, PC after reset
- `PC_STEP`, 1, PC increment (word-addressed memory)

Ports:
- `clk_i`  in  1  single clock; all state updates on its rising edge
- `rst_i`  in  1  reset, synchronous, active-high (`RST_ENABLE` = 1'b1)
- `stall_i`  in  6  pipeline stall vector; [5] blocks launching a new fetch; [4]=1 means IF/ID does not capture this cycle
- `flush_i`  in  1  exception flush; redirect to `flush_pc_i`
- `flush_pc_i`  in  ADDR_W  flush target
- `branch_flag_i`  in  1  taken branch from ID; redirect to `branch_target_i`
- `branch_target_i`  in  ADDR_W  branch target
- `inst_req_o`  out  1  fetch request, registered
- `inst_addr_o`  out  ADDR_W  fetch address, registered, stable while `inst_req_o`=1
- `inst_ack_i`  in  1  memory completes the request this cycle
- `inst_rdata_i`  in  INST_W  instruction, valid only with `inst_ack_i`
- `if_inst_o`  out  INST_W  instruction to IF/ID
- `if_PC_o`  out  ADDR_W  PC of `if_inst_o`
- `stallreq_o`  out  1  no valid instruction available this cycle

## Operation
- States: IDLE, FETCH, HOLD, DRAIN.
- Memory handshake: `inst_req_o`=1 with `inst_addr_o` held constant until `inst_ack_i`=1 is sampled. Zero-wait ack, in the same cycle as the request, is legal. Only one request is outstanding at a time.
- IDLE: `inst_req_o`=0. Moves to FETCH next cycle if `stall_i[5]`=0.
- FETCH: `inst_req_o`=1, `inst_addr_o`=PC.
  - ack and `stall_i[4]`=0: data goes straight to the outputs and IF/ID captures it. PC <= PC+PC_STEP. Stay in FETCH, or go to IDLE if `stall_i[5]`=1.
  - ack and `stall_i[4]`=1: capture {rdata, PC} into the hold buffer. PC <= PC+PC_STEP. Go to HOLD.
- HOLD: `inst_req_o`=0. Outputs come from the hold buffer. On the first cycle with `stall_i[4]`=0 the buffer is consumed and cleared, then go to FETCH (or IDLE if `stall_i[5]`=1).
- Valid output means (FETCH and ack) or HOLD. Otherwise `if_inst_o`=0 and `if_PC_o`=0, and `stallreq_o`=1.
- Redirect: `flush_i` has priority over `branch_flag_i`.
  - PC <= target.
  - The hold buffer is cleared.
  - Outputs are forced to 0 that cycle, and `stallreq_o`=0.
  - From FETCH without ack: go to DRAIN.
  - From FETCH with ack: discard the data and go to FETCH next cycle with the target.
  - From IDLE or HOLD: go to FETCH.
- DRAIN: keep `inst_req_o`=1 with the old address until ack. Discard the data; outputs stay 0. Then go to FETCH with the redirected PC. A further redirect during DRAIN overwrites PC and stays in DRAIN.
- Arithmetic: PC+PC_STEP wraps modulo 2^ADDR_W (16'hFFFF+1 → 16'h0000).
- Reset dominates all inputs, including mid-request. The outstanding request is abandoned; memory shares the same reset.

## Timing
- Reset values: state IDLE, PC=RESET_PC, hold empty, `inst_req_o`=0, `inst_addr_o`=RESET_PC, `if_inst_o`=0, `if_PC_o`=0, `stallreq_o`=0.
- First request is issued 1 cycle after reset deasserts. With zero-wait memory the first instruction is at the outputs in that same cycle.
- Throughput is 1 instruction/cycle with zero-wait memory and no stalls. Each wait cycle adds one cycle of `stallreq_o`=1.
- `if_inst_o`, `if_PC_o` and `stallreq_o` are combinational from `inst_ack_i`/`inst_rdata_i` and state. IF/ID registers them.
- The first fetch from a redirect target issues on the cycle after the redirect (FETCH path), or the cycle after the drain ack.

## Structure
- In `defines.v`: `INST_BUS_LENGTH`, `INST_ADDR_LENGTH`, `RST_ENABLE`, `ZERO16`, plus new state encodings `IF_IDLE`, `IF_FETCH`, `IF_HOLD`, `IF_DRAIN` (2 bits).
- One sub-module, `if_hold_buf`: a one-entry {inst, PC} register with valid, load and clear. All FSM and PC logic stays in the top module.

## Test plan
- Reset, then zero-wait memory returning 16'hA000+addr, no stalls: requests for addresses 0,1,2,… on consecutive cycles; outputs {16'hA000,0},{16'hA001,1}; `stallreq_o`=0 throughout.
- Memory acks 3 cycles after the request at PC=4: `stallreq_o`=1 for 3 cycles with outputs 0; `inst_addr_o` stays 4; the instruction appears with the ack.
- Ack at PC=6 while `stall_i[4]`=1 for 4 cycles: the hold buffer keeps {inst,6} visible every cycle; no request during HOLD; the request for 7 issues the cycle after the stall releases.
- `branch_flag_i`=1 with target 16'h0040 while the fetch of 9 is pending (ack 2 cycles later): DRAIN; the data for 9 is discarded; the next request is 16'h0040.
- Same cycle `flush_i`=1 (pc 16'h0100) and `branch_flag_i`=1 (16'h0040): the next fetch is 16'h0100.
- PC=16'hFFFF fetched: the next request is 16'h0000. Assert `rst_i` during a pending request: the following cycle `inst_req_o`=0 and PC=RESET_PC.
